controlador_busqueda_igual: RTL
===============================

Name: controlador_busqueda_igual

Overview:
Sequential search controller that time-shares a single n-bit equality comparator across an internal table of DEPTH entries. On a start request it latches a key and compares it against one table entry per clock, from index 0 upward, until a match is found or the table is exhausted. It then reports found/index with a done pulse. It is used by game/control logic that needs "is this value in the set, and where" without DEPTH parallel comparators.

Parameters:
N, 5, width of key and table entries
DEPTH, 8, number of table entries (power of 2, ≥2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request a search; sampled only in IDLE
clave  in  N  search key; latched in the cycle start is accepted
wr_en  in  1  table write strobe
wr_addr  in  $clog2(DEPTH)  table write index
wr_data  in  N  table write data
busy  out  1  high while scanning
done  out  1  one-cycle pulse when results become valid
encontrado  out  1  match found in last search
indice  out  $clog2(DEPTH)  index of first match (0 if none)
num_coincidencias  out  $clog2(DEPTH)+1  match count (see Optional Feature)

Behaviour:
- Reset (rst=1 at a clock edge): state IDLE; table cleared to 0; busy=0, done=0, encontrado=0, indice=0, num_coincidencias=0; latched key=0, pointer=0. rst asserted mid-scan aborts the scan; no done pulse is produced.
- States: IDLE, SCAN, DONE.
- IDLE: if start=1, latch clave, set pointer=0, clear the match counter, go to SCAN. Otherwise stay.
- SCAN: busy=1. Each cycle the comparator sees table[pointer] vs latched key.
  - Match (first-match mode): latch encontrado=1, indice=pointer, num_coincidencias=1; go to DONE.
  - No match and pointer==DEPTH-1: encontrado=0, indice=0, num_coincidencias=0; go to DONE.
  - Otherwise pointer+1; stay in SCAN.
- DONE: done=1 for exactly this cycle, busy=0; go to IDLE. start is ignored in DONE.
- Results hold from the DONE cycle until the next accepted start. At the cycle start is accepted, encontrado, indice and num_coincidencias are cleared.
- Latency: start accepted in cycle 0. A match at index i gives done in cycle i+2. No match gives done in cycle DEPTH+1.
- start is ignored while in SCAN or DONE; no queuing.
- Writes: accepted only in IDLE and DONE; wr_en is ignored in SCAN, so the table is stable during a scan. A write and an accepted start in the same IDLE cycle: the write takes effect, and the scan sees the new value.
- A key change on clave after acceptance has no effect on the search in progress.
- Pointer never wraps: the scan terminates at DEPTH-1.

Optional Feature:
Macro CONTAR_COINCIDENCIAS_EN.
- Defined: SCAN never terminates early and always visits all DEPTH entries. num_coincidencias counts every match (0..DEPTH). encontrado = count>0. indice = lowest matching index. done always falls in cycle DEPTH+1.
- Not defined: first-match early stop as described in Behaviour; num_coincidencias is only 0 or 1.

Decomposition:
- Shared package: state enum (IDLE, SCAN, DONE) and default N/DEPTH constants.
- One sub-module: comparador_igual #(.n(N)), the team's combinational equality comparator. It is instantiated once; its iguales output drives the match decision.
- Table storage and FSM live in this module.

Test Plan:
- Reset mid-scan: rst=1 during SCAN → next cycle busy=0, done never pulses, all outputs 0; a subsequent search reads an all-zero table.
- First match: N=5, DEPTH=8, table={3,7,12,7,0,0,0,31}, clave=7 → done in cycle 3, encontrado=1, indice=1; with CONTAR_COINCIDENCIAS_EN, done in cycle 9, num_coincidencias=2, indice=1.
- Miss: same table, clave=20 → done in cycle 9, encontrado=0, indice=0, busy high in cycles 1–8.
- Boundary entries: clave=3 → indice=0, done in cycle 2. clave=31 → indice=7, done in cycle 9.
- Ignored inputs: assert start and wr_en(addr=1, data=20) during SCAN → no restart, table[1] stays 7; the same write in IDLE then a search for 20 → indice=1.
- Same-cycle write+start in IDLE: write table[5]=9 with start, clave=9 → encontrado=1, indice=5.

Source files
------------

// File: rtl/controlador_busqueda_igual_pkg.sv
// ============================================================================
// Module      : controlador_busqueda_igual_pkg
// Description : Shared types and default sizes for the sequential equality
//               search controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package controlador_busqueda_igual_pkg;

    // Default key/entry width and table depth
    localparam int c_n_def     = 5;
    localparam int c_depth_def = 8;

    // Controller states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } estado_t;

endpackage : controlador_busqueda_igual_pkg

`default_nettype wire

// File: rtl/controlador_busqueda_igual_comparador.sv
// ============================================================================
// Module      : comparador_igual
// Description : Combinational n-bit equality comparator; the single shared
//               comparator time-multiplexed over the search table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module comparador_igual #(
    parameter int n = 5
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    output logic         iguales
);

    assign iguales = (a == b);

endmodule : comparador_igual

`default_nettype wire

// File: rtl/controlador_busqueda_igual.sv
// ============================================================================
// Module      : controlador_busqueda_igual
// Description : Sequential search controller. Latches a key on start and
//               compares it against one table entry per clock from index 0
//               upward, reporting found/index/match count with a done pulse.
//               Build option CONTAR_COINCIDENCIAS_EN: scan always visits every
//               entry and counts all matches instead of stopping at the first.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module controlador_busqueda_igual
    import controlador_busqueda_igual_pkg::*;
#(
    parameter int N     = c_n_def,
    parameter int DEPTH = c_depth_def
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [N-1:0]             clave,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [N-1:0]             wr_data,
    output logic                     busy,
    output logic                     done,
    output logic                     encontrado,
    output logic [$clog2(DEPTH)-1:0] indice,
    output logic [$clog2(DEPTH):0]   num_coincidencias
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = c_aw + 1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [N-1:0]    tabla_q [DEPTH];
    logic [N-1:0]    tabla_d [DEPTH];

    estado_t         estado_q, estado_d;
    logic [c_aw-1:0] ptr_q, ptr_d;
    logic [N-1:0]    clave_q, clave_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            encontrado_q, encontrado_d;
    logic [c_aw-1:0] indice_q, indice_d;
    logic [c_cw-1:0] num_q, num_d;
`ifdef CONTAR_COINCIDENCIAS_EN
    // Running totals of the full scan; published only when entering DONE
    logic [c_cw-1:0] acc_cnt_q, acc_cnt_d;
    logic [c_aw-1:0] acc_idx_q, acc_idx_d;
`endif

    logic            w_iguales;
    logic            w_ultimo;

    // Single shared comparator: current table entry vs latched key
    comparador_igual #(.n(N)) u_comparador (
        .a       (tabla_q[ptr_q]),
        .b       (clave_q),
        .iguales (w_iguales)
    );

    assign w_ultimo = (ptr_q == c_aw'(DEPTH - 1));

    // Table write port; frozen while scanning so the search sees a stable set
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            tabla_d[i] = tabla_q[i];
        end
        if (wr_en && (estado_q != ST_SCAN)) begin
            tabla_d[wr_addr] = wr_data;
        end
    end

    // Table storage, cleared on reset
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                tabla_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                tabla_q[i] <= tabla_d[i];
            end
        end
    end

    // Next-state and registered-output logic of the search FSM
    always_comb begin
        estado_d     = estado_q;
        ptr_d        = ptr_q;
        clave_d      = clave_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        encontrado_d = encontrado_q;
        indice_d     = indice_q;
        num_d        = num_q;
`ifdef CONTAR_COINCIDENCIAS_EN
        acc_cnt_d    = acc_cnt_q;
        acc_idx_d    = acc_idx_q;
`endif

        case (estado_q)
            ST_IDLE: begin
                if (start) begin
                    clave_d      = clave;
                    ptr_d        = '0;
                    encontrado_d = 1'b0;
                    indice_d     = '0;
                    num_d        = '0;
`ifdef CONTAR_COINCIDENCIAS_EN
                    acc_cnt_d    = '0;
                    acc_idx_d    = '0;
`endif
                    busy_d       = 1'b1;
                    estado_d     = ST_SCAN;
                end
            end

            ST_SCAN: begin
`ifdef CONTAR_COINCIDENCIAS_EN
                if (w_iguales) begin
                    // First hit fixes the reported index
                    if (acc_cnt_q == '0) begin
                        acc_idx_d = ptr_q;
                    end
                    acc_cnt_d = acc_cnt_q + c_cw'(1);
                end
                if (w_ultimo) begin
                    encontrado_d = (acc_cnt_d != '0);
                    indice_d     = acc_idx_d;
                    num_d        = acc_cnt_d;
                    done_d       = 1'b1;
                    estado_d     = ST_DONE;
                end else begin
                    ptr_d  = ptr_q + c_aw'(1);
                    busy_d = 1'b1;
                end
`else
                if (w_iguales) begin
                    encontrado_d = 1'b1;
                    indice_d     = ptr_q;
                    num_d        = c_cw'(1);
                    done_d       = 1'b1;
                    estado_d     = ST_DONE;
                end else if (w_ultimo) begin
                    encontrado_d = 1'b0;
                    indice_d     = '0;
                    num_d        = '0;
                    done_d       = 1'b1;
                    estado_d     = ST_DONE;
                end else begin
                    ptr_d  = ptr_q + c_aw'(1);
                    busy_d = 1'b1;
                end
`endif
            end

            ST_DONE: begin
                estado_d = ST_IDLE;
            end

            default: begin
                estado_d = ST_IDLE;
            end
        endcase
    end

    // FSM and result registers; reset aborts any scan without a done pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q     <= ST_IDLE;
            ptr_q        <= '0;
            clave_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            encontrado_q <= 1'b0;
            indice_q     <= '0;
            num_q        <= '0;
`ifdef CONTAR_COINCIDENCIAS_EN
            acc_cnt_q    <= '0;
            acc_idx_q    <= '0;
`endif
        end else begin
            estado_q     <= estado_d;
            ptr_q        <= ptr_d;
            clave_q      <= clave_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            encontrado_q <= encontrado_d;
            indice_q     <= indice_d;
            num_q        <= num_d;
`ifdef CONTAR_COINCIDENCIAS_EN
            acc_cnt_q    <= acc_cnt_d;
            acc_idx_q    <= acc_idx_d;
`endif
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign encontrado        = encontrado_q;
    assign indice            = indice_q;
    assign num_coincidencias = num_q;

endmodule : controlador_busqueda_igual

`default_nettype wire
